// File: rtl/pe_bus_responder_if.sv
// PE shared-bus signal bundle: PEs act as master, the responder as slave.
interface pe_bus_responder_if #(
    parameter int NUM_PE = 4
);
    logic [NUM_PE-1:0] bus_request;
    logic [NUM_PE-1:0] grant;
    logic              mem_readBus;
    logic              mem_writeBus;
    logic [31:0]       mem_addressBus;
    logic [31:0]       result_outBus;
    logic [4:0]        rs1OutBus;
    logic [4:0]        rs2OutBus;
    logic [4:0]        rdOutBus;
    logic              reg_selectBus;
    logic              read_enBus;
    logic              rd_writeBus;
    logic              mem_ackBus;
    logic [31:0]       memData;
    logic              data_ReadyBus;
    logic [31:0]       AmuxBus;
    logic [31:0]       BmuxBus;

    modport master (
        output bus_request,
        output mem_readBus,
        output mem_writeBus,
        output mem_addressBus,
        output result_outBus,
        output rs1OutBus,
        output rs2OutBus,
        output rdOutBus,
        output reg_selectBus,
        output read_enBus,
        output rd_writeBus,
        input  grant,
        input  mem_ackBus,
        input  memData,
        input  data_ReadyBus,
        input  AmuxBus,
        input  BmuxBus
    );

    modport slave (
        input  bus_request,
        input  mem_readBus,
        input  mem_writeBus,
        input  mem_addressBus,
        input  result_outBus,
        input  rs1OutBus,
        input  rs2OutBus,
        input  rdOutBus,
        input  reg_selectBus,
        input  read_enBus,
        input  rd_writeBus,
        output grant,
        output mem_ackBus,
        output memData,
        output data_ReadyBus,
        output AmuxBus,
        output BmuxBus
    );
endinterface

// File: rtl/pe_bus_responder.sv
// Responder for the PE shared bus: round-robin grant, global memory and
// shared register file served to whichever PE currently owns the bus.
module pe_bus_responder #(
    parameter int NUM_PE    = 4,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_LAT   = 2
) (
    input logic clk,
    input logic reset,
    pe_bus_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        OWN,
        MEM_WAIT,
        MEM_ACK,
        REG_RD,
        RELEASE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     nxt_ptr;
    logic [NUM_PE-1:0] sel_hot;
    logic              found;
    int                idx;

    logic [3:0]        cnt;
    logic [AW-1:0]     addr_q;
    logic [31:0]       data_q;
    logic              wr_q;

    logic [NUM_PE-1:0] grant_q;
    logic              ack_q;
    logic [31:0]       mem_data_q;
    logic              rdy_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;

    logic [31:0]       rf [32];
    logic [31:0]       mem [MEM_DEPTH];

    logic              cmd_mem;
    logic              cmd_wr;
    logic              cmd_rd;
    logic              own_req;
    logic              arb_en;

    logic [AW-1:0]     cmd_addr;
    logic              mem_go;
    logic              go_wr;
    logic [AW-1:0]     go_addr;
    logic [31:0]       go_data;
    logic              unused_addr;

    assign cmd_addr    = bus.mem_addressBus[AW+1:2];
    assign unused_addr = ^{bus.mem_addressBus[31:AW+2],
                           bus.mem_addressBus[1:0]};

    // Round-robin pick: first requester at or after rr_ptr, cyclically.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_PE; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PE;
            if (!found && bus.bus_request[PW'(idx)]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_hot      = '0;
        sel_hot[sel] = 1'b1;
        if (int'(sel) == NUM_PE - 1) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = sel + PW'(1);
        end
    end

    // Mutually exclusive command decode, memory ops take priority.
    always_comb begin
        cmd_mem = bus.mem_writeBus | bus.mem_readBus;
        cmd_wr  = !cmd_mem && bus.rd_writeBus;
        cmd_rd  = !cmd_mem && !bus.rd_writeBus && bus.read_enBus;
        own_req = bus.bus_request[owner];
        arb_en  = (state == IDLE) || (state == RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RELEASE: begin
                // The dead cycle doubles as the next arbitration slot.
                if (found) begin
                    state_nx = OWN;
                end else begin
                    state_nx = IDLE;
                end
            end
            OWN: begin
                unique case (1'b1)
                    cmd_mem: state_nx = (MEM_LAT == 0) ? MEM_ACK : MEM_WAIT;
                    cmd_wr:  state_nx = OWN;
                    cmd_rd:  state_nx = REG_RD;
                    default: begin
                        if (!own_req) begin
                            state_nx = RELEASE;
                        end
                    end
                endcase
            end
            MEM_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = MEM_ACK;
                end
            end
            MEM_ACK: state_nx = OWN;
            REG_RD:  state_nx = OWN;
            default: state_nx = IDLE;
        endcase
    end

    // With zero latency the op completes straight from the OWN sample.
    always_comb begin
        mem_go  = (state_nx == MEM_ACK);
        go_wr   = (state == OWN) ? bus.mem_writeBus : wr_q;
        go_addr = (state == OWN) ? cmd_addr : addr_q;
        go_data = (state == OWN) ? bus.result_outBus : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            grant_q    <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            ack_q      <= 1'b0;
            mem_data_q <= '0;
            rdy_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            ack_q <= (state_nx == MEM_ACK);
            rdy_q <= (state_nx == REG_RD);

            if (arb_en && found) begin
                grant_q <= sel_hot;
                owner   <= sel;
                rr_ptr  <= nxt_ptr;
            end else if (state_nx == RELEASE) begin
                grant_q <= '0;
            end

            if (state == OWN && cmd_mem) begin
                addr_q <= cmd_addr;
                data_q <= bus.result_outBus;
                wr_q   <= bus.mem_writeBus;
                cnt    <= 4'(MEM_LAT);
            end else if (state == MEM_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (mem_go && !go_wr) begin
                mem_data_q <= mem[go_addr];
            end

            if (state == OWN && cmd_rd) begin
                a_q <= rf[bus.rs1OutBus];
                b_q <= bus.reg_selectBus ? rf[bus.rs2OutBus] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_go && go_wr) begin
            mem[go_addr] <= go_data;
        end
    end

    // rf[0] is never written, so x0 always reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (state == OWN && cmd_wr && bus.rdOutBus != 5'd0) begin
            rf[bus.rdOutBus] <= bus.result_outBus;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.mem_ackBus    = ack_q;
    assign bus.memData       = mem_data_q;
    assign bus.data_ReadyBus = rdy_q;
    assign bus.AmuxBus       = a_q;
    assign bus.BmuxBus       = b_q;
endmodule

// File: tb/tb_pe_bus_responder.sv
// Directed bench for pe_bus_responder with a transaction-level model
// checked against every DUT output on each falling clock edge.
module tb_pe_bus_responder;
    localparam int NUM_PE    = 4;
    localparam int MEM_DEPTH = 256;
    localparam int MEM_LAT   = 2;

    logic clk = 1'b0;
    logic reset;

    pe_bus_responder_if #(.NUM_PE(NUM_PE)) bus ();

    pe_bus_responder #(
        .NUM_PE   (NUM_PE),
        .MEM_DEPTH(MEM_DEPTH),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [3:0]  m_grant;
    logic        m_ack;
    logic        m_rdy;
    logic [31:0] m_data;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_ptr;
    logic [31:0] m_rf [32];
    logic [31:0] m_mem [int];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("grant", 32'(bus.grant), 32'(m_grant));
            chk("mem_ack", 32'(bus.mem_ackBus), 32'(m_ack));
            chk("memData", bus.memData, m_data);
            chk("data_ready", 32'(bus.data_ReadyBus), 32'(m_rdy));
            chk("AmuxBus", bus.AmuxBus, m_a);
            chk("BmuxBus", bus.BmuxBus, m_b);
        end
    end

    function automatic int arb(input logic [3:0] req, input int ptr);
        for (int i = 0; i < NUM_PE; i++) begin
            if (req[(ptr + i) % NUM_PE]) return (ptr + i) % NUM_PE;
        end
        return -1;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2) % MEM_DEPTH;
    endfunction

    task automatic model_reset();
        m_grant = '0;
        m_ack   = 1'b0;
        m_rdy   = 1'b0;
        m_data  = '0;
        m_a     = '0;
        m_b     = '0;
        m_ptr   = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        bus.mem_readBus    = 1'b0;
        bus.mem_writeBus   = 1'b0;
        bus.mem_addressBus = '0;
        bus.result_outBus  = '0;
        bus.rs1OutBus      = '0;
        bus.rs2OutBus      = '0;
        bus.rdOutBus       = '0;
        bus.reg_selectBus  = 1'b0;
        bus.read_enBus     = 1'b0;
        bus.rd_writeBus    = 1'b0;
    endtask

    // Bus is free (idle or dead cycle): the next edge grants a requester.
    task automatic arb_step();
        int s;
        s = arb(bus.bus_request, m_ptr);
        step();
        if (s >= 0) begin
            m_grant = 4'(1 << s);
            m_ptr   = (s + 1) % NUM_PE;
        end else begin
            m_grant = '0;
        end
    endtask

    // Ack appears MEM_LAT+1 edges after the edge that samples the command.
    task automatic mem_op(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit drop);
        bus.mem_writeBus   = wr;
        bus.mem_readBus    = !wr;
        bus.mem_addressBus = addr;
        bus.result_outBus  = data;
        step();
        clear_cmds();
        if (drop) bus.bus_request = '0;
        repeat (MEM_LAT) step();
        step();
        m_ack = 1'b1;
        if (wr) m_mem[widx(addr)] = data;
        else m_data = m_mem[widx(addr)];
        step();
        m_ack = 1'b0;
    endtask

    task automatic rf_write(input logic [4:0] rd, input logic [31:0] data);
        bus.rd_writeBus   = 1'b1;
        bus.rdOutBus      = rd;
        bus.result_outBus = data;
        step();
        clear_cmds();
        if (rd != 5'd0) m_rf[rd] = data;
    endtask

    task automatic rf_read(input logic [4:0] rs1, input logic [4:0] rs2,
                           input bit sel);
        bus.read_enBus    = 1'b1;
        bus.rs1OutBus     = rs1;
        bus.rs2OutBus     = rs2;
        bus.reg_selectBus = sel;
        step();
        clear_cmds();
        m_rdy = 1'b1;
        m_a   = m_rf[rs1];
        m_b   = sel ? m_rf[rs2] : 32'd0;
        step();
        m_rdy = 1'b0;
    endtask

    task automatic release_to(input logic [3:0] req);
        bus.bus_request = req;
        step();
        m_grant = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_cmds();
        bus.bus_request = 4'b1111;
        model_reset();
        cmp_en = 1'b1;
        repeat (3) step();
        chk("reset_grant", 32'(bus.grant), 32'd0);

        reset = 1'b1;
        arb_step();
        chk("first_grant", 32'(bus.grant), 32'h1);
        bus.bus_request = 4'b0001;

        mem_op(1'b1, 32'h10, 32'h87654321, 1'b0);
        mem_op(1'b0, 32'h10, 32'h0, 1'b0);
        chk("read_0x10", bus.memData, 32'h87654321);
        mem_op(1'b1, 32'h414, 32'h0BADF00D, 1'b0);
        mem_op(1'b0, 32'h14, 32'h0, 1'b0);
        chk("wrap_0x14", bus.memData, 32'h0BADF00D);

        rf_write(5'd3, 32'h11111111);
        rf_write(5'd4, 32'h22222222);
        rf_read(5'd3, 5'd4, 1'b1);
        chk("rf_a", bus.AmuxBus, 32'h11111111);
        chk("rf_b", bus.BmuxBus, 32'h22222222);
        rf_read(5'd3, 5'd4, 1'b0);
        chk("rf_b_unsel", bus.BmuxBus, 32'h0);
        rf_write(5'd0, 32'hFFFFFFFF);
        rf_read(5'd0, 5'd3, 1'b1);
        chk("rf_x0", bus.AmuxBus, 32'h0);

        bus.read_enBus = 1'b1;
        bus.rs1OutBus  = 5'd3;
        mem_op(1'b1, 32'h20, 32'hCAFE0001, 1'b0);
        mem_op(1'b0, 32'h20, 32'h0, 1'b0);
        chk("memwr_over_rd", bus.memData, 32'hCAFE0001);

        bus.read_enBus = 1'b1;
        bus.rs1OutBus  = 5'd5;
        rf_write(5'd5, 32'h55555555);
        rf_read(5'd5, 5'd0, 1'b0);
        chk("wr_over_rd", bus.AmuxBus, 32'h55555555);

        release_to(4'b0000);
        arb_step();

        bus.bus_request = 4'b1010;
        arb_step();
        chk("rr_1", 32'(bus.grant), 32'h2);
        rf_write(5'd6, 32'h1);
        release_to(4'b1000);
        arb_step();
        chk("rr_2", 32'(bus.grant), 32'h8);
        bus.bus_request = 4'b1010;
        rf_write(5'd7, 32'h2);
        release_to(4'b0010);
        arb_step();
        chk("rr_3", 32'(bus.grant), 32'h2);
        rf_write(5'd8, 32'h3);
        release_to(4'b0000);
        arb_step();

        bus.bus_request = 4'b0100;
        arb_step();
        chk("drop_grant", 32'(bus.grant), 32'h4);
        mem_op(1'b0, 32'h10, 32'h0, 1'b1);
        chk("drop_data", bus.memData, 32'h87654321);
        step();
        m_grant = '0;
        arb_step();

        bus.bus_request = 4'b1000;
        arb_step();
        chk("abort_grant", 32'(bus.grant), 32'h8);
        bus.mem_writeBus   = 1'b1;
        bus.mem_addressBus = 32'h10;
        bus.result_outBus  = 32'hDEADBEEF;
        step();
        clear_cmds();
        step();
        reset = 1'b0;
        #1;
        model_reset();
        chk("abort_grant_now", 32'(bus.grant), 32'h0);
        chk("abort_ack_now", 32'(bus.mem_ackBus), 32'h0);
        step();
        reset = 1'b1;
        bus.bus_request = 4'b0010;
        arb_step();
        chk("post_rst_grant", 32'(bus.grant), 32'h2);
        mem_op(1'b0, 32'h10, 32'h0, 1'b0);
        chk("aborted_write", bus.memData, 32'h87654321);
        rf_read(5'd3, 5'd4, 1'b1);
        chk("rf_cleared_a", bus.AmuxBus, 32'h0);
        chk("rf_cleared_b", bus.BmuxBus, 32'h0);
        release_to(4'b0000);
        arb_step();
        step();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
